out_port_arbiter: RTL and testbench
===================================

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of input ports competing for one switch output.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the stall-cycle limit; it is used only when ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the asynchronous reset, active-low.
REQ-005 The block SHALL have port req, input, N_IN bits: per-input flit valid, one bit per input port.
REQ-006 The block SHALL have port tail, input, N_IN bits: per-input tail-flit marker, qualified by req.
REQ-007 The block SHALL have port busy_in, input, 1 bit: output buffer full; no transfer is allowed while it is high.
REQ-008 The block SHALL have port grant, output, N_IN bits: registered one-hot owner of the output, which also drives the mux select.
REQ-009 The block SHALL have port pop, output, N_IN bits: combinational one-hot dequeue strobe to the owning input buffer.
REQ-010 The block SHALL have port valid_out, output, 1 bit: combinational write strobe to the output buffer.
REQ-011 The block SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: registered one-cycle error pulse.

Function
REQ-013 The block SHALL implement exactly two states, IDLE and LOCKED.
REQ-014 In IDLE, with any req bit set, the block SHALL pick the winner round-robin:
- search starts at ptr+1 and proceeds upward, wrapping modulo N_IN;
- on the next edge it SHALL load grant with the winner (one-hot) and enter LOCKED.
REQ-015 In IDLE, with req all zero, the block SHALL keep grant=0 and stay in IDLE.
REQ-016 In LOCKED with owner g, a transfer SHALL occur in any cycle where req[g]=1 and busy_in=0:
- valid_out=1 and pop=grant in that same cycle;
- otherwise valid_out=0 and pop=0.
REQ-017 A transfer carrying tail[g]=1 SHALL cause, on the next edge: state IDLE, grant=0, ptr=g.
REQ-018 A single-flit packet (head also tail) SHALL release the lock after its single transfer.
REQ-019 While LOCKED, the block SHALL ignore req on all non-owner inputs and SHALL hold the lock when req[g] deasserts mid-packet (wormhole).
REQ-020 While LOCKED, busy_in=1 SHALL stall without releasing the lock.
REQ-021 Latency:
- req rising in cycle n SHALL produce grant in cycle n+1;
- the earliest transfer is in cycle n+1;
- after a tail transfer in cycle m, the next grant is in cycle m+2 (one IDLE arbitration cycle).
REQ-022 grant SHALL never have more than one bit set; pop SHALL always be a subset of grant.
REQ-023 Under contention, every requester with continuous req SHALL be granted within N_IN packets.

Reset
REQ-024 While rst=0, regardless of clk, the block SHALL force state=IDLE, grant=0, ptr=N_IN-1, locked=0, timeout_err=0, and the stall counter to 0.
REQ-025 Reset asserted mid-packet SHALL abort the packet; pop and valid_out SHALL be 0 from reset assertion onward.
REQ-026 After rst deasserts, the first arbitration SHALL favour input 0.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, the block SHALL:
- count LOCKED cycles without a transfer;
- clear the count on each transfer and on leaving LOCKED;
- when the count reaches TIMEOUT, on the next edge pulse timeout_err for one cycle, return to IDLE, clear grant, and set ptr=g.
REQ-028 Without ARB_TIMEOUT_EN, the block SHALL contain no counter, SHALL tie timeout_err to 0, and LOCKED SHALL persist indefinitely until a tail transfer.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Out of reset, req=4'b1111, all packets 2 flits, busy_in=0 -> grants in order 0,1,2,3,0; valid_out high 2 of every 3 cycles.
- req[2] only, 3-flit packet, busy_in high for 4 cycles mid-packet -> grant=4'b0100 held throughout; exactly 3 pop[2] pulses; lock released after the tail.
- Input 1 mid-packet, req[3] asserted -> no grant change until input 1's tail; input 3 granted 2 cycles after the tail transfer.
- rst pulled low with 2 of 4 flits sent -> grant=0, valid_out=0 immediately; after release, req=4'b1010 grants input 1.
- With ARB_TIMEOUT_EN and TIMEOUT=8, owner drops req after its head flit -> timeout_err pulses once 9 cycles later; another waiting requester is granted the next cycle.
- Single-flit packets alternating on inputs 0 and 3 -> each released after one transfer; grant never two-hot.

Source files
------------

// File: rtl/out_port_arbiter_if.sv
// Arbiter-side bundle for one switch output: per-input flit valid/tail in, grant/pop/strobes out.
// master = input buffers plus output buffer side, slave = out_port_arbiter.
interface out_port_arbiter_if #(
   parameter int N_IN = 4
);
   logic [N_IN-1:0] req;
   logic [N_IN-1:0] tail;
   logic            busy_in;
   logic [N_IN-1:0] grant;
   logic [N_IN-1:0] pop;
   logic            valid_out;
   logic            locked;
   logic            timeout_err;

   modport master (
      output req, tail, busy_in,
      input  grant, pop, valid_out, locked, timeout_err
   );

   modport slave (
      input  req, tail, busy_in,
      output grant, pop, valid_out, locked, timeout_err
   );
endinterface

// File: rtl/out_port_arbiter.sv
// Wormhole round-robin output arbiter: grant one cycle after req, lock until tail, busy_in stalls in place.
// Define ARB_TIMEOUT_EN to add a stall watchdog that drops a lock after TIMEOUT transfer-less cycles.
module out_port_arbiter #(
   parameter int N_IN    = 4,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   out_port_arbiter_if.slave arb
);
   localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

   if (N_IN < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("out_port_arbiter: N_IN must be >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_nxt_state;
   logic [N_IN-1:0] r_grant;
   logic [N_IN-1:0] w_nxt_grant;
   logic [N_IN-1:0] w_win_oh;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_nxt_ptr;
   logic [PW-1:0]   w_owner_idx;
   logic            w_found;
   logic            w_xfer;
   logic            w_tail_xfer;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_stall_cnt;
   logic [CW-1:0] w_nxt_cnt;
   logic          r_timeout_err;
   logic          w_nxt_terr;
   logic          w_timeout;
`endif

   // Round-robin search starts just above the last owner and wraps.
   always_comb begin
      w_win_oh = '0;
      w_found  = 1'b0;
      for (int i = 1; i <= N_IN; i++) begin
         if (!w_found && arb.req[PW'((int'(r_ptr) + i) % N_IN)]) begin
            w_win_oh[PW'((int'(r_ptr) + i) % N_IN)] = 1'b1;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_owner_idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (r_grant[PW'(i)]) begin
            w_owner_idx = PW'(i);
         end
      end
   end

   assign w_xfer      = (r_state == LOCKED) && (|(arb.req & r_grant)) && !arb.busy_in;
   assign w_tail_xfer = w_xfer && (|(arb.tail & r_grant));

`ifdef ARB_TIMEOUT_EN
   // Fires in the stall cycle that brings the count to TIMEOUT.
   assign w_timeout = (r_state == LOCKED) && !w_xfer &&
                      (r_stall_cnt == CW'(TIMEOUT - 1));
`endif

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_grant = r_grant;
      w_nxt_ptr   = r_ptr;
`ifdef ARB_TIMEOUT_EN
      w_nxt_cnt   = '0;
      w_nxt_terr  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nxt_state = LOCKED;
               w_nxt_grant = w_win_oh;
            end else begin
               w_nxt_grant = '0;
            end
         end
         LOCKED: begin
            if (w_tail_xfer) begin
               w_nxt_state = IDLE;
               w_nxt_grant = '0;
               w_nxt_ptr   = w_owner_idx;
            end
`ifdef ARB_TIMEOUT_EN
            else if (w_timeout) begin
               w_nxt_state = IDLE;
               w_nxt_grant = '0;
               w_nxt_ptr   = w_owner_idx;
               w_nxt_terr  = 1'b1;
            end else if (!w_xfer) begin
               w_nxt_cnt = r_stall_cnt + CW'(1);
            end
`endif
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_grant = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_ptr         <= PW'(N_IN - 1);
`ifdef ARB_TIMEOUT_EN
         r_stall_cnt   <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_state       <= w_nxt_state;
         r_grant       <= w_nxt_grant;
         r_ptr         <= w_nxt_ptr;
`ifdef ARB_TIMEOUT_EN
         r_stall_cnt   <= w_nxt_cnt;
         r_timeout_err <= w_nxt_terr;
`endif
      end
   end

   assign arb.grant     = r_grant;
   assign arb.pop       = w_xfer ? r_grant : '0;
   assign arb.valid_out = w_xfer;
   assign arb.locked    = (r_state == LOCKED);
`ifdef ARB_TIMEOUT_EN
   assign arb.timeout_err = r_timeout_err;
`else
   assign arb.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: vector table for round-robin rotation, hand sequences for corner cases.
module tb_out_port_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   out_port_arbiter_if #(.N_IN(N)) bus ();

   out_port_arbiter #(.N_IN(N), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] tail;
      logic       busy;
      logic [3:0] grant;
      logic [3:0] pop;
      logic       vld;
      logic       lck;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] t, input logic b,
                               input logic [3:0] g, input logic [3:0] p, input logic v,
                               input logic l);
      vec_t x;
      x.req = r; x.tail = t; x.busy = b; x.grant = g; x.pop = p; x.vld = v; x.lck = l;
      return x;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic b);
      bus.req     = r;
      bus.tail    = t;
      bus.busy_in = b;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic inv();
      check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      check("pop_subset", 32'((bus.pop & ~bus.grant) == 4'b0), 32'd1);
   endtask

   task automatic chk_out(input string nm, input logic [3:0] g, input logic [3:0] p,
                          input logic v, input logic l);
      check({nm, "_grant"}, 32'(bus.grant), 32'(g));
      check({nm, "_pop"}, 32'(bus.pop), 32'(p));
      check({nm, "_vld"}, 32'(bus.valid_out), 32'(v));
      check({nm, "_locked"}, 32'(bus.locked), 32'(l));
   endtask

   initial begin
      int         vcnt;
      int         pops;
      int         held;
      logic [3:0] oh;
      logic [3:0] in;
      logic       b;
      logic [3:0] t;

      // Rotation 0,1,2,3,0 with 2-flit packets: idle, head, tail per packet.
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         tbl[3*k]     = mk(4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
         tbl[3*k + 1] = mk(4'hF, 4'h0, 1'b0, oh, oh, 1'b1, 1'b1);
         tbl[3*k + 2] = mk(4'hF, 4'hF, 1'b0, oh, oh, 1'b1, 1'b1);
      end

      rst = 1'b1;
      bus.req = '0; bus.tail = '0; bus.busy_in = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_out("reset", 4'h0, 4'h0, 1'b0, 1'b0);
      check("reset_terr", 32'(bus.timeout_err), 32'd0);
      adv();
      rst = 1'b1;

      vcnt = 0;
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].req, tbl[i].tail, tbl[i].busy);
         chk_out($sformatf("rr_v%0d", i), tbl[i].grant, tbl[i].pop, tbl[i].vld, tbl[i].lck);
         check("rr_terr", 32'(bus.timeout_err), 32'd0);
         inv();
         if (bus.valid_out) vcnt++;
         adv();
      end
      check("rr_vld_count", 32'(vcnt), 32'd10);

      // 3-flit packet on input 2 with a 4-cycle busy stall after the head.
      drive(4'b0100, 4'h0, 1'b0);
      chk_out("stall_idle", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      pops = 0; held = 0;
      for (int i = 0; i < 7; i++) begin
         b = (i >= 1 && i <= 4);
         t = (i == 6) ? 4'b0100 : 4'b0000;
         drive(4'b0100, t, b);
         if (bus.pop[2]) pops++;
         if (bus.grant == 4'b0100) held++;
         check("stall_vld", 32'(bus.valid_out), 32'(!b));
         inv();
         adv();
      end
      check("stall_pops", 32'(pops), 32'd3);
      check("stall_held", 32'(held), 32'd7);
      drive(4'b0000, 4'h0, 1'b0);
      chk_out("stall_release", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();

      // Input 1 owns the output while input 3 starts requesting.
      drive(4'b0010, 4'h0, 1'b0);
      chk_out("worm_idle", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b0010, 4'h0, 1'b0);
      chk_out("worm_head", 4'b0010, 4'b0010, 1'b1, 1'b1);
      adv();
      drive(4'b1010, 4'h0, 1'b0);
      chk_out("worm_body", 4'b0010, 4'b0010, 1'b1, 1'b1);
      adv();
      drive(4'b1010, 4'b0010, 1'b0);
      chk_out("worm_tail", 4'b0010, 4'b0010, 1'b1, 1'b1);
      adv();
      drive(4'b1010, 4'h0, 1'b0);
      chk_out("worm_arb", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b1010, 4'b1000, 1'b0);
      chk_out("worm_in3", 4'b1000, 4'b1000, 1'b1, 1'b1);
      adv();
      drive(4'b0000, 4'h0, 1'b0);
      chk_out("worm_done", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();

      // Reset lands after 2 of 4 flits of an input-0 packet.
      drive(4'b0001, 4'h0, 1'b0);
      adv();
      drive(4'b0001, 4'h0, 1'b0);
      chk_out("rstmid_f1", 4'b0001, 4'b0001, 1'b1, 1'b1);
      adv();
      drive(4'b0001, 4'h0, 1'b0);
      chk_out("rstmid_f2", 4'b0001, 4'b0001, 1'b1, 1'b1);
      adv();
      rst = 1'b0;
      #1;
      chk_out("rstmid_async", 4'h0, 4'h0, 1'b0, 1'b0);
      check("rstmid_terr", 32'(bus.timeout_err), 32'd0);
      adv();
      adv();
      rst = 1'b1;
      drive(4'b1010, 4'h0, 1'b0);
      chk_out("rstmid_idle", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b1010, 4'b0010, 1'b0);
      chk_out("rstmid_grant1", 4'b0010, 4'b0010, 1'b1, 1'b1);
      adv();
      drive(4'b0000, 4'h0, 1'b0);
      check("rstmid_release", 32'(bus.locked), 32'd0);
      adv();

      // Single-flit packets alternating between inputs 0 and 3.
      for (int k = 0; k < 6; k++) begin
         in = k[0] ? 4'b1000 : 4'b0001;
         drive(in, in, 1'b0);
         chk_out($sformatf("sf%0d_idle", k), 4'h0, 4'h0, 1'b0, 1'b0);
         inv();
         adv();
         drive(in, in, 1'b0);
         chk_out($sformatf("sf%0d_xfer", k), in, in, 1'b1, 1'b1);
         inv();
         adv();
      end
      drive(4'b0000, 4'h0, 1'b0);
      check("sf_release", 32'(bus.locked), 32'd0);
      adv();

      // Owner 0 sends its head then drops req while input 2 waits.
      drive(4'b0101, 4'h0, 1'b0);
      chk_out("to_idle", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b0101, 4'h0, 1'b0);
      chk_out("to_head", 4'b0001, 4'b0001, 1'b1, 1'b1);
      adv();
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         drive(4'b0100, 4'h0, 1'b0);
         chk_out($sformatf("to_stall%0d", k), 4'b0001, 4'h0, 1'b0, 1'b1);
         check("to_terr_low", 32'(bus.timeout_err), 32'd0);
         adv();
      end
      drive(4'b0100, 4'h0, 1'b0);
      check("to_terr_pulse", 32'(bus.timeout_err), 32'd1);
      chk_out("to_dropped", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b0100, 4'b0100, 1'b0);
      check("to_terr_clear", 32'(bus.timeout_err), 32'd0);
      chk_out("to_next", 4'b0100, 4'b0100, 1'b1, 1'b1);
      adv();
`else
      for (int k = 0; k < 20; k++) begin
         drive(4'b0100, 4'h0, 1'b0);
         chk_out($sformatf("hold%0d", k), 4'b0001, 4'h0, 1'b0, 1'b1);
         check("hold_terr", 32'(bus.timeout_err), 32'd0);
         adv();
      end
      drive(4'b0101, 4'b0001, 1'b0);
      chk_out("hold_tail", 4'b0001, 4'b0001, 1'b1, 1'b1);
      adv();
      drive(4'b0100, 4'h0, 1'b0);
      chk_out("hold_arb", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();
      drive(4'b0100, 4'b0100, 1'b0);
      chk_out("hold_next", 4'b0100, 4'b0100, 1'b1, 1'b1);
      adv();
`endif
      drive(4'b0000, 4'h0, 1'b0);
      chk_out("final", 4'h0, 4'h0, 1'b0, 1'b0);
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
